// File: rtl/mmio_finisher.sv
// -----------------------------------------------------------------------------
// mmio_finisher
//
// Memory-mapped responder on the core data bus. The CPU uses it to end a
// simulation run (FINISH) and to emit console text (CONSOLE_TX). It handles one
// transaction at a time and decodes a 16-byte window at BASE_ADDR:
//   +0x0 FINISH     W: wdata[0]=1 with full mask sets the sticky finish flag
//                      and captures wdata[XLEN-1:1] as exit code (first wins)
//                   R: {finish_code, finished}
//   +0x4 CONSOLE_TX W: wmask[0]=1 pushes wdata[7:0] into the console FIFO
//                   R: 0
//   +0x8 STATUS     R: {fifo count zero-extended, finished}; writes ignored
//   +0xC reserved   R: 0; writes ignored
// Accesses outside the window or not word aligned respond with resp_error=1
// and have no side effect.
//
// Ports
//   clk, reset            clock, synchronous active-low reset
//   req_valid/req_ready   request handshake (req_ready=1 only while idle)
//   req_wen/addr/wdata/wmask  request payload
//   resp_valid/resp_ready response handshake (registered response)
//   resp_rdata/resp_error response payload
//   tx_valid/tx_ready/tx_data console byte stream (FIFO head)
//   finished/finish_code  sticky finish flag and captured exit code
//
// Optional build macro: MMIO_FINISHER_DISPLAY_EN (simulation only). When
// defined, every popped console byte is echoed with $write and the run ends
// the cycle finished rises ($finish for code 0, $fatal otherwise). When
// undefined the block contains no system tasks.
// -----------------------------------------------------------------------------
module mmio_finisher #(
    parameter int               XLEN       = 32,
    parameter logic [XLEN-1:0]  BASE_ADDR  = 32'h0300_0000,
    parameter int               FIFO_DEPTH = 8
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic            req_wen,
    input  logic [XLEN-1:0] req_addr,
    input  logic [XLEN-1:0] req_wdata,
    input  logic [3:0]      req_wmask,
    output logic            resp_valid,
    input  logic            resp_ready,
    output logic [XLEN-1:0] resp_rdata,
    output logic            resp_error,
    output logic            tx_valid,
    input  logic            tx_ready,
    output logic [7:0]      tx_data,
    output logic            finished,
    output logic [XLEN-2:0] finish_code
);

    localparam int            PW      = $clog2(FIFO_DEPTH);
    localparam int            CW      = PW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_FIFO = 2'd1,
        RESP      = 2'd2
    } state_t;

    state_t          state_r;
    state_t          state_nxt_s;

    // Console FIFO storage and bookkeeping
    logic [7:0]      fifo_mem_r [FIFO_DEPTH];
    logic [PW-1:0]   wr_ptr_r;
    logic [PW-1:0]   rd_ptr_r;
    logic [CW-1:0]   count_r;
    logic [7:0]      pend_byte_r;

    logic            finished_r;
    logic [XLEN-2:0] finish_code_r;

    logic            resp_valid_r;
    logic [XLEN-1:0] resp_rdata_r;
    logic            resp_error_r;

    // Decode of the request currently presented on the bus
    logic            in_window_s;
    logic            aligned_s;
    logic            addr_ok_s;
    logic [1:0]      reg_sel_s;
    logic [XLEN-1:0] rd_data_s;

    // FIFO and transaction control
    logic            fifo_full_s;
    logic            pop_s;
    logic            push_s;
    logic [7:0]      push_data_s;
    logic            tx_write_s;
    logic            stall_s;
    logic            accept_s;
    logic            fin_set_s;
    logic            wait_go_s;

    // Address decode and read-data selection for the incoming request
    always_comb begin
        in_window_s = 1'b0;
        aligned_s   = 1'b0;
        addr_ok_s   = 1'b0;
        reg_sel_s   = 2'd0;
        rd_data_s   = {XLEN{1'b0}};
        // BASE_ADDR is 16-byte aligned, so the window is exactly the set of
        // addresses sharing its upper bits.
        in_window_s = (req_addr[XLEN-1:4] == BASE_ADDR[XLEN-1:4]);
        aligned_s   = (req_addr[1:0] == 2'b00);
        addr_ok_s   = in_window_s && aligned_s;
        reg_sel_s   = req_addr[3:2];
        if (addr_ok_s && !req_wen) begin
            case (reg_sel_s)
                2'd0:    rd_data_s = {finish_code_r, finished_r};
                2'd2:    rd_data_s = {{(XLEN-1-CW){1'b0}}, count_r, finished_r};
                default: rd_data_s = {XLEN{1'b0}};
            endcase
        end else begin
            rd_data_s = {XLEN{1'b0}};
        end
    end

    // Transaction qualifiers and FIFO push/pop selection
    always_comb begin
        fifo_full_s = 1'b0;
        pop_s       = 1'b0;
        tx_write_s  = 1'b0;
        stall_s     = 1'b0;
        accept_s    = 1'b0;
        fin_set_s   = 1'b0;
        wait_go_s   = 1'b0;
        push_s      = 1'b0;
        push_data_s = pend_byte_r;

        fifo_full_s = (count_r == DEPTH_C);
        pop_s       = (count_r != {CW{1'b0}}) && tx_ready;
        tx_write_s  = addr_ok_s && req_wen && (reg_sel_s == 2'd1) && req_wmask[0];
        // A pop in the same cycle frees a slot, so a full FIFO only stalls
        // the write when the sink is not draining.
        stall_s     = tx_write_s && fifo_full_s && !pop_s;
        accept_s    = req_valid && (state_r == IDLE);
        fin_set_s   = accept_s && addr_ok_s && req_wen && (reg_sel_s == 2'd0)
                      && req_wdata[0] && (req_wmask == 4'hF) && !finished_r;
        wait_go_s   = (state_r == WAIT_FIFO) && (!fifo_full_s || pop_s);

        if (accept_s && tx_write_s && !stall_s) begin
            push_s      = 1'b1;
            push_data_s = req_wdata[7:0];
        end else if (wait_go_s) begin
            push_s      = 1'b1;
            push_data_s = pend_byte_r;
        end else begin
            push_s      = 1'b0;
            push_data_s = pend_byte_r;
        end
    end

    // Next-state logic for the single-transaction FSM
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (req_valid) begin
                    state_nxt_s = stall_s ? WAIT_FIFO : RESP;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            WAIT_FIFO: begin
                if (wait_go_s) begin
                    state_nxt_s = RESP;
                end else begin
                    state_nxt_s = WAIT_FIFO;
                end
            end
            RESP: begin
                if (resp_ready) begin
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = RESP;
                end
            end
            default: state_nxt_s = IDLE;
        endcase
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // FIFO pointers and occupancy; push+pop together leaves count unchanged
    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr_r <= {PW{1'b0}};
            rd_ptr_r <= {PW{1'b0}};
            count_r  <= {CW{1'b0}};
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PW'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PW'(1);
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + CW'(1);
                2'b01:   count_r <= count_r - CW'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    // FIFO storage; contents are qualified by the pointers, so no reset needed
    always_ff @(posedge clk) begin
        if (push_s) begin
            fifo_mem_r[wr_ptr_r] <= push_data_s;
        end
    end

    // Hold the console byte of an accepted write for a possible FIFO stall
    always_ff @(posedge clk) begin
        if (!reset) begin
            pend_byte_r <= 8'h00;
        end else if (accept_s) begin
            pend_byte_r <= req_wdata[7:0];
        end
    end

    // Sticky finish flag; the first qualifying write keeps its exit code
    always_ff @(posedge clk) begin
        if (!reset) begin
            finished_r    <= 1'b0;
            finish_code_r <= {(XLEN-1){1'b0}};
        end else if (fin_set_s) begin
            finished_r    <= 1'b1;
            finish_code_r <= req_wdata[XLEN-1:1];
        end
    end

    // Registered response: loaded on completion, held until consumed
    always_ff @(posedge clk) begin
        if (!reset) begin
            resp_valid_r <= 1'b0;
            resp_rdata_r <= {XLEN{1'b0}};
            resp_error_r <= 1'b0;
        end else if (accept_s && !stall_s) begin
            resp_valid_r <= 1'b1;
            resp_rdata_r <= rd_data_s;
            resp_error_r <= !addr_ok_s;
        end else if (wait_go_s) begin
            // Only an in-window CONSOLE_TX write can reach WAIT_FIFO.
            resp_valid_r <= 1'b1;
            resp_rdata_r <= {XLEN{1'b0}};
            resp_error_r <= 1'b0;
        end else if ((state_r == RESP) && resp_ready) begin
            resp_valid_r <= 1'b0;
            resp_rdata_r <= {XLEN{1'b0}};
            resp_error_r <= 1'b0;
        end
    end

    assign req_ready   = (state_r == IDLE);
    assign resp_valid  = resp_valid_r;
    assign resp_rdata  = resp_rdata_r;
    assign resp_error  = resp_error_r;
    assign tx_valid    = (count_r != {CW{1'b0}});
    assign tx_data     = fifo_mem_r[rd_ptr_r];
    assign finished    = finished_r;
    assign finish_code = finish_code_r;

`ifdef MMIO_FINISHER_DISPLAY_EN
    logic finished_d_r;

    // Delayed finish flag used to spot the cycle finished first reads high
    always_ff @(posedge clk) begin
        if (!reset) begin
            finished_d_r <= 1'b0;
        end else begin
            finished_d_r <= finished_r;
        end
    end

    // Simulation console echo and end-of-run handling
    always @(posedge clk) begin
        if (reset && pop_s) begin
            $write("%c", tx_data);
        end
        if (reset && finished_r && !finished_d_r) begin
            $display("finish code=%0d", finish_code_r);
            if (finish_code_r == {(XLEN-1){1'b0}}) begin
                $finish;
            end else begin
                $fatal(1, "nonzero exit code %0d", finish_code_r);
            end
        end
    end
`endif

endmodule

// File: tb/tb_mmio_finisher.sv
// -----------------------------------------------------------------------------
// Self-checking bench for mmio_finisher. Expected responses are pushed to a
// scoreboard queue when a request is driven and popped when the response
// arrives; console bytes are tracked in a second queue.
// -----------------------------------------------------------------------------
module tb_mmio_finisher;

    localparam int          XLEN  = 32;
    localparam logic [31:0] BASE  = 32'h0300_0000;
    localparam int          DEPTH = 8;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_wen;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [3:0]  req_wmask;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_rdata;
    logic        resp_error;
    logic        tx_valid;
    logic        tx_ready;
    logic [7:0]  tx_data;
    logic        finished;
    logic [30:0] finish_code;

    mmio_finisher #(
        .XLEN       (XLEN),
        .BASE_ADDR  (BASE),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_wen     (req_wen),
        .req_addr    (req_addr),
        .req_wdata   (req_wdata),
        .req_wmask   (req_wmask),
        .resp_valid  (resp_valid),
        .resp_ready  (resp_ready),
        .resp_rdata  (resp_rdata),
        .resp_error  (resp_error),
        .tx_valid    (tx_valid),
        .tx_ready    (tx_ready),
        .tx_data     (tx_data),
        .finished    (finished),
        .finish_code (finish_code)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic        err;
        logic [31:0] rdata;
    } exp_t;

    typedef struct {
        logic        wen;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wmask;
    } req_t;

    exp_t        sb[$];
    logic [7:0]  tx_q[$];
    logic        m_finished;
    logic [30:0] m_code;
    int          total = 0;
    int          bad   = 0;
    int unsigned acc_cyc;

    // Reference STATUS value: {fifo count zero-extended, finished}
    function automatic logic [31:0] status_model();
        return {27'h0, 4'(tx_q.size()), m_finished};
    endfunction

    task automatic send(input logic wen, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [3:0] wmask);
        int n;
        n = 0;
        @(negedge clk);
        req_valid = 1'b1;
        req_wen   = wen;
        req_addr  = addr;
        req_wdata = wdata;
        req_wmask = wmask;
        while (!req_ready && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) begin
            total++;
            bad++;
            $display("FAIL accept_timeout addr=%h req_ready=%b want 1", addr, req_ready);
        end
        @(posedge clk);
        acc_cyc = cyc;
        #1 req_valid = 1'b0;
    endtask

    task automatic get_resp(output logic [31:0] rdata, output logic err, output int lat);
        int n;
        n = 0;
        while (!resp_valid && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (resp_valid) begin
            rdata = resp_rdata;
            err   = resp_error;
            lat   = n;
        end else begin
            rdata = 'x;
            err   = 1'bx;
            lat   = -1;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic xact(input logic wen, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [3:0] wmask, output logic [31:0] rdata,
                        output logic err, output int lat);
        send(wen, addr, wdata, wmask);
        get_resp(rdata, err, lat);
    endtask

    task automatic test_reset;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        total++;
        if ({req_ready, resp_valid, resp_rdata, resp_error, tx_valid, finished, finish_code}
            !== {1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 31'h0}) begin
            bad++;
            $display("FAIL reset_outputs got rr=%b rv=%b rd=%h er=%b tv=%b fin=%b code=%h want rr=1 others 0",
                     req_ready, resp_valid, resp_rdata, resp_error, tx_valid, finished, finish_code);
        end
        reset = 1'b1;
        sb.delete();
        tx_q.delete();
        m_finished = 1'b0;
        m_code     = 31'h0;
    endtask

    task automatic test_finish;
        logic [31:0] rd;
        logic        er;
        int          lat;
        exp_t        e;
        sb.push_back(exp_t'{err: 1'b0, rdata: 32'h0});
        xact(1'b1, BASE, 32'h0000_0001, 4'hF, rd, er, lat);
        m_finished = 1'b1;
        m_code     = 31'd0;
        e = sb.pop_front();
        total++;
        if (lat !== 0 || er !== e.err || rd !== e.rdata) begin
            bad++;
            $display("FAIL finish_write got lat=%0d err=%b rdata=%h want lat=0 err=%b rdata=%h",
                     lat, er, rd, e.err, e.rdata);
        end
        total++;
        if ({finished, finish_code} !== {m_finished, m_code}) begin
            bad++;
            $display("FAIL finish_flag got fin=%b code=%0d want fin=%b code=%0d",
                     finished, finish_code, m_finished, m_code);
        end
        sb.push_back(exp_t'{err: 1'b0, rdata: {m_code, m_finished}});
        xact(1'b0, BASE, 32'h0, 4'h0, rd, er, lat);
        e = sb.pop_front();
        total++;
        if (er !== e.err || rd !== e.rdata) begin
            bad++;
            $display("FAIL finish_read got err=%b rdata=%h want err=%b rdata=%h", er, rd, e.err, e.rdata);
        end
    endtask

    task automatic test_finish_retain;
        logic [31:0] rd;
        logic        er;
        int          lat;
        exp_t        e;
        logic [31:0] wd [4];
        logic [3:0]  wm [4];
        wd = '{32'h0000_0003, 32'h0000_002A, 32'h0000_002B, 32'h0000_0005};
        wm = '{4'h7, 4'hF, 4'hF, 4'hF};
        for (int i = 0; i < 4; i++) begin
            sb.push_back(exp_t'{err: 1'b0, rdata: 32'h0});
            xact(1'b1, BASE, wd[i], wm[i], rd, er, lat);
            if (wd[i][0] && wm[i] == 4'hF && !m_finished) begin
                m_finished = 1'b1;
                m_code     = wd[i][31:1];
            end
            e = sb.pop_front();
            total++;
            if (er !== e.err || rd !== e.rdata) begin
                bad++;
                $display("FAIL retain_write%0d got err=%b rdata=%h want err=%b rdata=%h",
                         i, er, rd, e.err, e.rdata);
            end
        end
        total++;
        if ({finished, finish_code} !== {m_finished, m_code}) begin
            bad++;
            $display("FAIL retain_code got fin=%b code=%0d want fin=%b code=%0d",
                     finished, finish_code, m_finished, m_code);
        end
        sb.push_back(exp_t'{err: 1'b0, rdata: {m_code, m_finished}});
        xact(1'b0, BASE, 32'h0, 4'h0, rd, er, lat);
        e = sb.pop_front();
        total++;
        if (er !== e.err || rd !== e.rdata) begin
            bad++;
            $display("FAIL retain_read got err=%b rdata=%h want err=%b rdata=%h", er, rd, e.err, e.rdata);
        end
    endtask

    task automatic test_console_fifo;
        logic [31:0] rd;
        logic        er;
        int          lat;
        exp_t        e;
        logic [7:0]  b;
        tx_ready = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            b = 8'h41 + 8'(i);
            sb.push_back(exp_t'{err: 1'b0, rdata: 32'h0});
            tx_q.push_back(b);
            xact(1'b1, BASE + 32'h4, {24'h0, b}, 4'h1, rd, er, lat);
            e = sb.pop_front();
            total++;
            if (er !== e.err || rd !== e.rdata) begin
                bad++;
                $display("FAIL tx_write%0d got err=%b rdata=%h want err=%b rdata=%h",
                         i, er, rd, e.err, e.rdata);
            end
        end
        // Ninth byte with the FIFO full and no sink: must stall
        sb.push_back(exp_t'{err: 1'b0, rdata: 32'h0});
        send(1'b1, BASE + 32'h4, 32'h0000_0049, 4'h1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            total++;
            if ({req_ready, resp_valid} !== 2'b00) begin
                bad++;
                $display("FAIL stall_cycle%0d got req_ready=%b resp_valid=%b want 0 0",
                         i, req_ready, resp_valid);
            end
        end
        total++;
        if ({tx_valid, tx_data} !== {1'b1, tx_q[0]}) begin
            bad++;
            $display("FAIL head_before_pulse got valid=%b data=%h want 1 %h", tx_valid, tx_data, tx_q[0]);
        end
        tx_ready = 1'b1;
        @(posedge clk);
        #1 tx_ready = 1'b0;
        b = tx_q.pop_front();
        tx_q.push_back(8'h49);
        get_resp(rd, er, lat);
        e = sb.pop_front();
        total++;
        if (lat !== 0 || er !== e.err || rd !== e.rdata) begin
            bad++;
            $display("FAIL wait_resp got lat=%0d err=%b rdata=%h want lat=0 err=%b rdata=%h",
                     lat, er, rd, e.err, e.rdata);
        end
        sb.push_back(exp_t'{err: 1'b0, rdata: status_model()});
        xact(1'b0, BASE + 32'h8, 32'h0, 4'h0, rd, er, lat);
        e = sb.pop_front();
        total++;
        if (er !== e.err || rd !== e.rdata || rd !== 32'h10) begin
            bad++;
            $display("FAIL status_full got err=%b rdata=%h want err=%b rdata=%h", er, rd, e.err, e.rdata);
        end
        @(negedge clk);
        tx_ready = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            total++;
            if ({tx_valid, tx_data} !== {1'b1, tx_q[0]}) begin
                bad++;
                $display("FAIL drain%0d got valid=%b data=%h want 1 %h", i, tx_valid, tx_data, tx_q[0]);
            end
            b = tx_q.pop_front();
            @(negedge clk);
        end
        tx_ready = 1'b0;
        total++;
        if (tx_valid !== 1'b0) begin
            bad++;
            $display("FAIL drain_empty got tx_valid=%b want 0", tx_valid);
        end
    endtask

    task automatic test_errors;
        logic [31:0] rd;
        logic        er;
        int          lat;
        exp_t        e;
        logic        ex_err;
        req_t        tbl [9];
        tbl = '{
            '{1'b0, BASE + 32'h2,  32'h0,          4'h0},
            '{1'b0, BASE + 32'h10, 32'h0,          4'h0},
            '{1'b0, BASE - 32'h4,  32'h0,          4'h0},
            '{1'b1, BASE + 32'h1,  32'h0000_0001,  4'hF},
            '{1'b1, BASE + 32'h4,  32'h0000_005A,  4'hE},
            '{1'b1, BASE + 32'h8,  32'h0000_FFFF,  4'hF},
            '{1'b0, BASE + 32'hC,  32'h0,          4'h0},
            '{1'b1, BASE + 32'hC,  32'hFFFF_FFFF,  4'hF},
            '{1'b0, BASE + 32'h8,  32'h0,          4'h0}
        };
        for (int i = 0; i < 9; i++) begin
            ex_err = !(tbl[i].addr >= BASE && tbl[i].addr <= BASE + 32'hF && tbl[i].addr[1:0] == 2'b00);
            sb.push_back(exp_t'{err: ex_err, rdata: (tbl[i].wen || ex_err) ? 32'h0 : status_model()});
            xact(tbl[i].wen, tbl[i].addr, tbl[i].wdata, tbl[i].wmask, rd, er, lat);
            e = sb.pop_front();
            total++;
            if (er !== e.err || rd !== e.rdata) begin
                bad++;
                $display("FAIL decode%0d addr=%h got err=%b rdata=%h want err=%b rdata=%h",
                         i, tbl[i].addr, er, rd, e.err, e.rdata);
            end
        end
        total++;
        if ({finished, tx_valid} !== {m_finished, 1'b0}) begin
            bad++;
            $display("FAIL decode_no_effect got fin=%b tx_valid=%b want fin=%b tx_valid=0",
                     finished, tx_valid, m_finished);
        end
    endtask

    task automatic test_resp_hold;
        logic [31:0] rd;
        logic        er;
        int          lat;
        exp_t        e;
        logic [7:0]  b;
        tx_ready = 1'b0;
        sb.push_back(exp_t'{err: 1'b0, rdata: 32'h0});
        tx_q.push_back(8'h78);
        xact(1'b1, BASE + 32'h4, 32'h0000_0078, 4'h1, rd, er, lat);
        e = sb.pop_front();
        total++;
        if (er !== e.err || rd !== e.rdata) begin
            bad++;
            $display("FAIL hold_setup got err=%b rdata=%h want err=%b rdata=%h", er, rd, e.err, e.rdata);
        end
        resp_ready = 1'b0;
        sb.push_back(exp_t'{err: 1'b0, rdata: status_model()});
        send(1'b0, BASE + 32'h8, 32'h0, 4'h0);
        e = sb.pop_front();
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            total++;
            if ({resp_valid, resp_rdata, resp_error, req_ready} !== {1'b1, e.rdata, e.err, 1'b0}) begin
                bad++;
                $display("FAIL hold_cycle%0d got rv=%b rd=%h er=%b rr=%b want rv=1 rd=%h er=%b rr=0",
                         i, resp_valid, resp_rdata, resp_error, req_ready, e.rdata, e.err);
            end
        end
        resp_ready = 1'b1;
        @(posedge clk);
        #1;
        total++;
        if ({req_ready, resp_valid} !== 2'b10) begin
            bad++;
            $display("FAIL hold_release got req_ready=%b resp_valid=%b want 1 0", req_ready, resp_valid);
        end
        @(negedge clk);
        tx_ready = 1'b1;
        total++;
        if ({tx_valid, tx_data} !== {1'b1, tx_q[0]}) begin
            bad++;
            $display("FAIL hold_byte got valid=%b data=%h want 1 %h", tx_valid, tx_data, tx_q[0]);
        end
        @(negedge clk);
        tx_ready = 1'b0;
        b = tx_q.pop_front();
    endtask

    task automatic test_back_to_back;
        logic [31:0] rd;
        logic        er;
        int          lat;
        exp_t        e;
        int unsigned c [3];
        sb.push_back(exp_t'{err: 1'b0, rdata: 32'h0});
        xact(1'b1, BASE, 32'h0000_0007, 4'hF, rd, er, lat);
        c[0] = acc_cyc;
        m_finished = 1'b1;
        m_code     = 31'd3;
        e = sb.pop_front();
        total++;
        if (er !== e.err || rd !== e.rdata) begin
            bad++;
            $display("FAIL b2b_write got err=%b rdata=%h want err=%b rdata=%h", er, rd, e.err, e.rdata);
        end
        sb.push_back(exp_t'{err: 1'b0, rdata: {m_code, m_finished}});
        xact(1'b0, BASE, 32'h0, 4'h0, rd, er, lat);
        c[1] = acc_cyc;
        e = sb.pop_front();
        total++;
        if (er !== e.err || rd !== e.rdata) begin
            bad++;
            $display("FAIL b2b_finish_read got err=%b rdata=%h want err=%b rdata=%h", er, rd, e.err, e.rdata);
        end
        sb.push_back(exp_t'{err: 1'b0, rdata: status_model()});
        xact(1'b0, BASE + 32'h8, 32'h0, 4'h0, rd, er, lat);
        c[2] = acc_cyc;
        e = sb.pop_front();
        total++;
        if (er !== e.err || rd !== e.rdata) begin
            bad++;
            $display("FAIL b2b_status_read got err=%b rdata=%h want err=%b rdata=%h", er, rd, e.err, e.rdata);
        end
        total++;
        if ((c[1] - c[0]) !== 2 || (c[2] - c[1]) !== 2) begin
            bad++;
            $display("FAIL b2b_spacing got %0d %0d want 2 2", c[1] - c[0], c[2] - c[1]);
        end
    endtask

    task automatic test_reset_in_wait;
        logic [31:0] rd;
        logic        er;
        int          lat;
        exp_t        e;
        int          seen;
        tx_ready = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            sb.push_back(exp_t'{err: 1'b0, rdata: 32'h0});
            tx_q.push_back(8'h61 + 8'(i));
            xact(1'b1, BASE + 32'h4, {24'h0, 8'h61 + 8'(i)}, 4'h1, rd, er, lat);
            e = sb.pop_front();
            total++;
            if (er !== e.err || rd !== e.rdata) begin
                bad++;
                $display("FAIL rst_fill%0d got err=%b rdata=%h want err=%b rdata=%h",
                         i, er, rd, e.err, e.rdata);
            end
        end
        sb.push_back(exp_t'{err: 1'b0, rdata: 32'h0});
        send(1'b1, BASE + 32'h4, 32'h0000_007A, 4'h1);
        @(negedge clk);
        total++;
        if ({req_ready, resp_valid, finished} !== 3'b001) begin
            bad++;
            $display("FAIL rst_in_wait got rr=%b rv=%b fin=%b want 0 0 1", req_ready, resp_valid, finished);
        end
        reset = 1'b0;
        @(negedge clk);
        total++;
        if ({req_ready, resp_valid, resp_rdata, resp_error, tx_valid, finished, finish_code}
            !== {1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 31'h0}) begin
            bad++;
            $display("FAIL rst_mid_outputs got rr=%b rv=%b rd=%h er=%b tv=%b fin=%b code=%h want rr=1 others 0",
                     req_ready, resp_valid, resp_rdata, resp_error, tx_valid, finished, finish_code);
        end
        reset = 1'b1;
        sb.delete();
        tx_q.delete();
        m_finished = 1'b0;
        m_code     = 31'h0;
        seen = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (resp_valid) seen++;
        end
        total++;
        if (seen !== 0) begin
            bad++;
            $display("FAIL rst_dropped got resp_valid cycles=%0d want 0", seen);
        end
        sb.push_back(exp_t'{err: 1'b0, rdata: {m_code, m_finished}});
        xact(1'b0, BASE, 32'h0, 4'h0, rd, er, lat);
        e = sb.pop_front();
        total++;
        if (er !== e.err || rd !== e.rdata) begin
            bad++;
            $display("FAIL rst_finish_read got err=%b rdata=%h want err=%b rdata=%h", er, rd, e.err, e.rdata);
        end
    endtask

    initial begin
        reset      = 1'b0;
        req_valid  = 1'b0;
        req_wen    = 1'b0;
        req_addr   = 32'h0;
        req_wdata  = 32'h0;
        req_wmask  = 4'h0;
        resp_ready = 1'b1;
        tx_ready   = 1'b0;
        m_finished = 1'b0;
        m_code     = 31'h0;
        acc_cyc    = 0;

        test_reset();
        test_finish();
        test_reset();
        test_finish_retain();
        test_reset();
        test_console_fifo();
        test_errors();
        test_resp_hold();
        test_back_to_back();
        test_reset_in_wait();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired at time %0t", $time);
        $fatal(1, "watchdog");
    end

endmodule
